// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants, FSM encoding and operand classification
// used by the Booth multiplier and the SRT divider datapaths.
package fp32_pkg;

    localparam int          BIAS    = 127;
    localparam int          ITERS   = 13;
    localparam logic [7:0]  EXP_INF = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_NORM,
        ST_ROUND
    } state_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_ZERO,
        SP_INF,
        SP_NAN
    } special_t;

    // NaN (or inf times zero) wins over inf, which wins over zero; exp==0 counts as zero.
    function automatic special_t classify(
        input logic [7:0]  a_exp,
        input logic [22:0] a_man,
        input logic [7:0]  b_exp,
        input logic [22:0] b_man
    );
        logic     a_nan;
        logic     b_nan;
        logic     a_inf;
        logic     b_inf;
        logic     a_zero;
        logic     b_zero;
        special_t cls;
        a_nan  = (a_exp == EXP_INF) && (a_man != 23'd0);
        b_nan  = (b_exp == EXP_INF) && (b_man != 23'd0);
        a_inf  = (a_exp == EXP_INF) && (a_man == 23'd0);
        b_inf  = (b_exp == EXP_INF) && (b_man == 23'd0);
        a_zero = (a_exp == 8'd0);
        b_zero = (b_exp == 8'd0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            cls = SP_NAN;
        end else if (a_inf || b_inf) begin
            cls = SP_INF;
        end else if (a_zero || b_zero) begin
            cls = SP_ZERO;
        end else begin
            cls = SP_NONE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/booth4_pp_sel.sv
// Radix-4 Booth digit decode: three multiplier bits select 0, +/-M or +/-2M
// as a 26-bit two's-complement partial product.
module booth4_pp_sel (
    input  logic [2:0]  digit,
    input  logic [23:0] mcand,
    output logic        neg,
    output logic        zero,
    output logic        two,
    output logic [25:0] pp
);

    logic [25:0] mag;

    always_comb begin
        neg  = digit[2];
        zero = (digit == 3'b000) || (digit == 3'b111);
        two  = (digit == 3'b011) || (digit == 3'b100);
        mag  = two ? {1'b0, mcand, 1'b0} : {2'b00, mcand};
        if (zero) begin
            pp = 26'd0;
        end else if (neg) begin
            pp = ~mag + 26'd1;
        end else begin
            pp = mag;
        end
    end

endmodule

// File: rtl/fp32_booth4_multiplier.sv
// Sequential fp32 multiplier: radix-4 Booth mantissa product, normalise, round-to-nearest-even.
// Optional status port flags[3:0] = {invalid, overflow, underflow, inexact} with FPMUL_STATUS_EN.
module fp32_booth4_multiplier
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        Asign,
    input  logic [7:0]  Aexp,
    input  logic [22:0] Amantissa,
    input  logic        Bsign,
    input  logic [7:0]  Bexp,
    input  logic [22:0] Bmantissa,
    output logic [31:0] p,
    output logic        done,
    output logic        busy
`ifdef FPMUL_STATUS_EN
    ,
    output logic [3:0]  flags
`endif
);

    localparam logic [9:0] BIAS10    = 10'(BIAS);
    localparam logic [3:0] LAST_STEP = 4'(ITERS - 1);

    state_t             state;
    logic [3:0]         cnt;
    logic               a_sign_q;
    logic               b_sign_q;
    logic [7:0]         a_exp_q;
    logic [7:0]         b_exp_q;
    logic [22:0]        a_man_q;
    logic [22:0]        b_man_q;
    logic [23:0]        mcand;
    logic [26:0]        mplr;
    logic [49:0]        acc;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    special_t           special_r;
    logic [22:0]        frac_r;
    logic               guard_r;
    logic               sticky_r;

    logic               pp_neg;
    logic               pp_zero;
    logic               pp_two_unused;
    logic [25:0]        pp;
    logic [49:0]        pp_shifted;
    logic [1:0]         acc_hi_unused;

    logic [47:0]        prod;
    logic [22:0]        frac_n;
    logic               guard_n;
    logic               sticky_n;

    logic               round_inc;
    logic [23:0]        rounded;
    logic signed [9:0]  exp_fin;
    logic               ovf;
    logic               unf;
    logic [31:0]        result;

    booth4_pp_sel u_pp_sel (
        .digit (mplr[2:0]),
        .mcand (mcand),
        .neg   (pp_neg),
        .zero  (pp_zero),
        .two   (pp_two_unused),
        .pp    (pp)
    );

    // Partial product i carries weight 4^i, so it is aligned by 2*cnt before accumulation.
    assign pp_shifted    = {{24{pp_neg & ~pp_zero}}, pp} << {cnt, 1'b0};
    assign acc_hi_unused = acc[49:48];

    always_comb begin
        prod = acc[47:0];
        if (prod[47]) begin
            frac_n   = prod[46:24];
            guard_n  = prod[23];
            sticky_n = |prod[22:0];
        end else begin
            frac_n   = prod[45:23];
            guard_n  = prod[22];
            sticky_n = |prod[21:0];
        end
    end

    // A carry out of the 24-bit rounded significand leaves the fraction at zero and bumps the exponent.
    always_comb begin
        round_inc = guard_r & (sticky_r | frac_r[0]);
        rounded   = {1'b0, frac_r} + {23'd0, round_inc};
        exp_fin   = exp_r + $signed({9'd0, rounded[23]});
        ovf       = (exp_fin >= 10'sd255);
        unf       = (exp_fin <= 10'sd0);
        case (special_r)
            SP_NAN:  result = QNAN;
            SP_INF:  result = {sign_r, EXP_INF, 23'd0};
            SP_ZERO: result = {sign_r, 31'd0};
            default: begin
                if (ovf) begin
                    result = {sign_r, EXP_INF, 23'd0};
                end else if (unf) begin
                    result = {sign_r, 31'd0};
                end else begin
                    result = {sign_r, exp_fin[7:0], rounded[22:0]};
                end
            end
        endcase
    end

`ifdef FPMUL_STATUS_EN
    logic [3:0] flags_n;

    always_comb begin
        flags_n = 4'b0000;
        case (special_r)
            SP_NAN:  flags_n = 4'b1000;
            SP_NONE: flags_n = {1'b0, ovf, unf, guard_r | sticky_r | ovf | unf};
            default: flags_n = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flags <= 4'b0000;
        end else if (state == ST_ROUND) begin
            flags <= flags_n;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            a_sign_q  <= 1'b0;
            b_sign_q  <= 1'b0;
            a_exp_q   <= 8'd0;
            b_exp_q   <= 8'd0;
            a_man_q   <= 23'd0;
            b_man_q   <= 23'd0;
            mcand     <= 24'd0;
            mplr      <= 27'd0;
            acc       <= 50'd0;
            sign_r    <= 1'b0;
            exp_r     <= 10'sd0;
            special_r <= SP_NONE;
            frac_r    <= 23'd0;
            guard_r   <= 1'b0;
            sticky_r  <= 1'b0;
            p         <= 32'd0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= start;
                    if (start) begin
                        a_sign_q <= Asign;
                        b_sign_q <= Bsign;
                        a_exp_q  <= Aexp;
                        b_exp_q  <= Bexp;
                        a_man_q  <= Amantissa;
                        b_man_q  <= Bmantissa;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    mcand     <= (a_exp_q != 8'd0) ? {1'b1, a_man_q} : 24'd0;
                    mplr      <= {2'b00, (b_exp_q != 8'd0) ? {1'b1, b_man_q} : 24'd0, 1'b0};
                    acc       <= 50'd0;
                    cnt       <= 4'd0;
                    sign_r    <= a_sign_q ^ b_sign_q;
                    exp_r     <= $signed({2'b00, a_exp_q}) + $signed({2'b00, b_exp_q})
                                 - $signed(BIAS10);
                    special_r <= classify(a_exp_q, a_man_q, b_exp_q, b_man_q);
                    state     <= ST_ITER;
                end
                ST_ITER: begin
                    acc  <= acc + pp_shifted;
                    mplr <= {2'b00, mplr[26:2]};
                    if (cnt == LAST_STEP) begin
                        cnt   <= 4'd0;
                        state <= ST_NORM;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_NORM: begin
                    frac_r   <= frac_n;
                    guard_r  <= guard_n;
                    sticky_r <= sticky_n;
                    if (prod[47]) begin
                        exp_r <= exp_r + 10'sd1;
                    end
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    p     <= result;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_booth4_multiplier.sv
// Directed-vector bench for fp32_booth4_multiplier; checks flags too when FPMUL_STATUS_EN is defined.
module tb_fp32_booth4_multiplier;

    localparam int NV = 19;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        Asign = 1'b0;
    logic [7:0]  Aexp = 8'd0;
    logic [22:0] Amantissa = 23'd0;
    logic        Bsign = 1'b0;
    logic [7:0]  Bexp = 8'd0;
    logic [22:0] Bmantissa = 23'd0;
    logic [31:0] p;
    logic        done;
    logic        busy;
`ifdef FPMUL_STATUS_EN
    logic [3:0]  flags;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] vecA [0:NV-1] = '{
        32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h7F000000, 32'h00800000,
        32'h00000000, 32'h7FC00001, 32'h3F800001, 32'h3F800003, 32'h3FC00001,
        32'h3F918E00, 32'h80000001, 32'h7F800000, 32'hBF800000, 32'h3F800000,
        32'h3F000000, 32'h7F000000, 32'h7F000000, 32'hFF800000};
    logic [31:0] vecB [0:NV-1] = '{
        32'h40000000, 32'h3F000000, 32'h3F800001, 32'h7F000000, 32'h00800000,
        32'h7F800000, 32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000,
        32'h3FE12000, 32'h3F800000, 32'hC0000000, 32'hC0000000, 32'h00800000,
        32'h00800000, 32'h3F800000, 32'h40000000, 32'h00000000};
    logic [31:0] vecP [0:NV-1] = '{
        32'h40400000, 32'hBFC00000, 32'h3F800002, 32'h7F800000, 32'h00000000,
        32'h7FC00000, 32'h7FC00000, 32'h3FC00002, 32'h3FC00004, 32'h40100001,
        32'h40000000, 32'h80000000, 32'hFF800000, 32'h40000000, 32'h00800000,
        32'h00000000, 32'h7F000000, 32'h7F800000, 32'h7FC00000};
    logic [3:0]  vecF [0:NV-1] = '{
        4'b0000, 4'b0000, 4'b0001, 4'b0101, 4'b0011,
        4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001,
        4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
        4'b0011, 4'b0000, 4'b0101, 4'b1000};

    fp32_booth4_multiplier dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .Asign     (Asign),
        .Aexp      (Aexp),
        .Amantissa (Amantissa),
        .Bsign     (Bsign),
        .Bexp      (Bexp),
        .Bmantissa (Bmantissa),
        .p         (p),
        .done      (done),
        .busy      (busy)
`ifdef FPMUL_STATUS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic setOperands(input logic [31:0] a, input logic [31:0] b);
        Asign     = a[31];
        Aexp      = a[30:23];
        Amantissa = a[22:0];
        Bsign     = b[31];
        Bexp      = b[30:23];
        Bmantissa = b[22:0];
    endtask

    // Start pulse spans one rising edge; lat counts edges after the sampling edge until done is seen.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input string tag, output int lat);
        @(negedge clk);
        setOperands(a, b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        checkOutput({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic waitForDone(inout int lat);
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic countDones(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        string tag;

        repeat (3) @(negedge clk);
        checkOutput("reset_p", p, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
`ifdef FPMUL_STATUS_EN
        checkOutput("reset_flags", {28'd0, flags}, 32'd0);
`endif
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            tag = $sformatf("v%0d", i);
            applyStimulus(vecA[i], vecB[i], tag, lat);
            checkOutput({tag, "_latency"}, 32'(lat), 32'd16);
            checkOutput({tag, "_p"}, p, vecP[i]);
            checkOutput({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
`ifdef FPMUL_STATUS_EN
            checkOutput({tag, "_flags"}, {28'd0, flags}, {28'd0, vecF[i]});
`endif
            @(negedge clk);
            checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            checkOutput({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
            checkOutput({tag, "_p_held"}, p, vecP[i]);
        end

        // A second start while busy must be ignored and must not queue another operation.
        @(negedge clk);
        setOperands(32'h3FC00000, 32'h40000000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (5) begin
            @(negedge clk);
            lat++;
        end
        setOperands(32'hC0400000, 32'h3F000000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat++;
        setOperands(32'h00000000, 32'h00000000);
        waitForDone(lat);
        checkOutput("ignore_latency", 32'(lat), 32'd16);
        checkOutput("ignore_p", p, 32'h40400000);
        countDones(24, seen);
        checkOutput("ignore_no_second_done", 32'(seen), 32'd0);

        // Reset mid-operation clears outputs at once and suppresses the pending done.
        @(negedge clk);
        setOperands(32'hC0400000, 32'h3F000000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("abort_p", p, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        countDones(25, seen);
        checkOutput("abort_no_done", 32'(seen), 32'd0);
        checkOutput("abort_p_held", p, 32'd0);

        applyStimulus(32'h3F800001, 32'h3FC00000, "after_abort", lat);
        checkOutput("after_abort_latency", 32'(lat), 32'd16);
        checkOutput("after_abort_p", p, 32'h3FC00002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
